// File: rtl/axi_arbiter_2to1.sv
// Two-master to one-slave AXI arbiter. Write and read paths are arbitrated independently (round-robin).
// Only grant, state, busy and pointer are registered; every channel is a combinational mux.
module axi_arbiter_2to1 #(
    parameter int AXI_ID_WIDTH = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int LEN_WIDTH    = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   m0_awaddr,
    input  logic [AXI_ID_WIDTH-1:0] m0_awid,
    input  logic [LEN_WIDTH-1:0]    m0_awlen,
    input  logic                    m0_awvalid,
    output logic                    m0_awready,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic [AXI_ID_WIDTH-1:0] m0_wid,
    input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
    input  logic                    m0_wlast,
    input  logic                    m0_wvalid,
    output logic                    m0_wready,
    output logic [1:0]              m0_bresp,
    output logic [AXI_ID_WIDTH-1:0] m0_bid,
    output logic                    m0_bvalid,
    input  logic                    m0_bready,
    input  logic [ADDR_WIDTH-1:0]   m0_araddr,
    input  logic [AXI_ID_WIDTH-1:0] m0_arid,
    input  logic [LEN_WIDTH-1:0]    m0_arlen,
    input  logic                    m0_arvalid,
    output logic                    m0_arready,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    output logic [AXI_ID_WIDTH-1:0] m0_rid,
    output logic [1:0]              m0_rresp,
    output logic                    m0_rlast,
    output logic                    m0_rvalid,
    input  logic                    m0_rready,
    input  logic [ADDR_WIDTH-1:0]   m1_awaddr,
    input  logic [AXI_ID_WIDTH-1:0] m1_awid,
    input  logic [LEN_WIDTH-1:0]    m1_awlen,
    input  logic                    m1_awvalid,
    output logic                    m1_awready,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [AXI_ID_WIDTH-1:0] m1_wid,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
    input  logic                    m1_wlast,
    input  logic                    m1_wvalid,
    output logic                    m1_wready,
    output logic [1:0]              m1_bresp,
    output logic [AXI_ID_WIDTH-1:0] m1_bid,
    output logic                    m1_bvalid,
    input  logic                    m1_bready,
    input  logic [ADDR_WIDTH-1:0]   m1_araddr,
    input  logic [AXI_ID_WIDTH-1:0] m1_arid,
    input  logic [LEN_WIDTH-1:0]    m1_arlen,
    input  logic                    m1_arvalid,
    output logic                    m1_arready,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic [AXI_ID_WIDTH-1:0] m1_rid,
    output logic [1:0]              m1_rresp,
    output logic                    m1_rlast,
    output logic                    m1_rvalid,
    input  logic                    m1_rready,
    output logic [ADDR_WIDTH-1:0]   s_awaddr,
    output logic [AXI_ID_WIDTH-1:0] s_awid,
    output logic [LEN_WIDTH-1:0]    s_awlen,
    output logic                    s_awvalid,
    input  logic                    s_awready,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    output logic [AXI_ID_WIDTH-1:0] s_wid,
    output logic [DATA_WIDTH/8-1:0] s_wstrb,
    output logic                    s_wlast,
    output logic                    s_wvalid,
    input  logic                    s_wready,
    input  logic [1:0]              s_bresp,
    input  logic [AXI_ID_WIDTH-1:0] s_bid,
    input  logic                    s_bvalid,
    output logic                    s_bready,
    output logic [ADDR_WIDTH-1:0]   s_araddr,
    output logic [AXI_ID_WIDTH-1:0] s_arid,
    output logic [LEN_WIDTH-1:0]    s_arlen,
    output logic                    s_arvalid,
    input  logic                    s_arready,
    input  logic [DATA_WIDTH-1:0]   s_rdata,
    input  logic [AXI_ID_WIDTH-1:0] s_rid,
    input  logic [1:0]              s_rresp,
    input  logic                    s_rlast,
    input  logic                    s_rvalid,
    output logic                    s_rready,
    output logic                    wr_gnt,
    output logic                    rd_gnt,
    output logic                    wr_busy,
    output logic                    rd_busy
);

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

    wr_state_t wr_state;
    rd_state_t rd_state;
    logic      wr_ptr;
    logic      rd_ptr;
    logic      wr_pick;
    logic      rd_pick;

    // A lone requester wins outright; the pointer only breaks ties.
    assign wr_pick = (m0_awvalid && m1_awvalid) ? wr_ptr : m1_awvalid;
    assign rd_pick = (m0_arvalid && m1_arvalid) ? rd_ptr : m1_arvalid;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_state <= W_IDLE;
            wr_ptr   <= 1'b0;
            wr_gnt   <= 1'b0;
            wr_busy  <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: if (m0_awvalid || m1_awvalid) begin
                    wr_state <= W_ADDR;
                    wr_gnt   <= wr_pick;
                    wr_ptr   <= ~wr_pick;
                    wr_busy  <= 1'b1;
                end
                W_ADDR: if (s_awvalid && s_awready) wr_state <= W_DATA;
                W_DATA: if (s_wvalid && s_wready && s_wlast) wr_state <= W_RESP;
                W_RESP: if (s_bvalid && s_bready) begin
                    wr_state <= W_IDLE;
                    wr_busy  <= 1'b0;
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_state <= R_IDLE;
            rd_ptr   <= 1'b0;
            rd_gnt   <= 1'b0;
            rd_busy  <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: if (m0_arvalid || m1_arvalid) begin
                    rd_state <= R_ADDR;
                    rd_gnt   <= rd_pick;
                    rd_ptr   <= ~rd_pick;
                    rd_busy  <= 1'b1;
                end
                R_ADDR: if (s_arvalid && s_arready) rd_state <= R_DATA;
                R_DATA: if (s_rvalid && s_rready && s_rlast) begin
                    rd_state <= R_IDLE;
                    rd_busy  <= 1'b0;
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // Write channels: each is open only in its own state, otherwise everything reads 0.
    always_comb begin
        s_awaddr = '0; s_awid = '0; s_awlen = '0; s_awvalid = 1'b0;
        m0_awready = 1'b0; m1_awready = 1'b0;
        s_wdata = '0; s_wid = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0;
        m0_wready = 1'b0; m1_wready = 1'b0;
        m0_bresp = '0; m0_bid = '0; m0_bvalid = 1'b0;
        m1_bresp = '0; m1_bid = '0; m1_bvalid = 1'b0;
        s_bready = 1'b0;
        case (wr_state)
            W_ADDR: begin
                s_awaddr  = wr_gnt ? m1_awaddr  : m0_awaddr;
                s_awid    = wr_gnt ? m1_awid    : m0_awid;
                s_awlen   = wr_gnt ? m1_awlen   : m0_awlen;
                s_awvalid = wr_gnt ? m1_awvalid : m0_awvalid;
                m0_awready = !wr_gnt && s_awready;
                m1_awready = wr_gnt && s_awready;
            end
            W_DATA: begin
                s_wdata  = wr_gnt ? m1_wdata  : m0_wdata;
                s_wid    = wr_gnt ? m1_wid    : m0_wid;
                s_wstrb  = wr_gnt ? m1_wstrb  : m0_wstrb;
                s_wlast  = wr_gnt ? m1_wlast  : m0_wlast;
                s_wvalid = wr_gnt ? m1_wvalid : m0_wvalid;
                m0_wready = !wr_gnt && s_wready;
                m1_wready = wr_gnt && s_wready;
            end
            W_RESP: begin
                if (wr_gnt) begin
                    m1_bresp = s_bresp; m1_bid = s_bid; m1_bvalid = s_bvalid;
                    s_bready = m1_bready;
                end else begin
                    m0_bresp = s_bresp; m0_bid = s_bid; m0_bvalid = s_bvalid;
                    s_bready = m0_bready;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        s_araddr = '0; s_arid = '0; s_arlen = '0; s_arvalid = 1'b0;
        m0_arready = 1'b0; m1_arready = 1'b0;
        m0_rdata = '0; m0_rid = '0; m0_rresp = '0; m0_rlast = 1'b0; m0_rvalid = 1'b0;
        m1_rdata = '0; m1_rid = '0; m1_rresp = '0; m1_rlast = 1'b0; m1_rvalid = 1'b0;
        s_rready = 1'b0;
        case (rd_state)
            R_ADDR: begin
                s_araddr  = rd_gnt ? m1_araddr  : m0_araddr;
                s_arid    = rd_gnt ? m1_arid    : m0_arid;
                s_arlen   = rd_gnt ? m1_arlen   : m0_arlen;
                s_arvalid = rd_gnt ? m1_arvalid : m0_arvalid;
                m0_arready = !rd_gnt && s_arready;
                m1_arready = rd_gnt && s_arready;
            end
            R_DATA: begin
                if (rd_gnt) begin
                    m1_rdata = s_rdata; m1_rid = s_rid; m1_rresp = s_rresp;
                    m1_rlast = s_rlast; m1_rvalid = s_rvalid;
                    s_rready = m1_rready;
                end else begin
                    m0_rdata = s_rdata; m0_rid = s_rid; m0_rresp = s_rresp;
                    m0_rlast = s_rlast; m0_rvalid = s_rvalid;
                    s_rready = m0_rready;
                end
            end
            default: ;
        endcase
    end

endmodule
